// File: rtl/lampfpu_sqrt_core_if.sv
// Start/result handshake between the FPU sqrt wrapper (master) and the
// radix-2 restoring square-root core (slave).
interface lampfpu_sqrt_core_if #(
  parameter int MANT_W = 8,
  parameter int RES_W  = 2 * MANT_W
);

  // Handshake: the master raises doSqrt_i for one cycle while busy_o is low
  // and valid_o is not pending. s_i, is_exp_odd_i and special_case_i are
  // sampled on that same edge only. The slave answers with a single-cycle
  // valid_o, and res_o is valid in that cycle. res_o then holds until the
  // next result. No back-pressure exists: starts issued while busy_o is high
  // are dropped, not queued.
  logic              doSqrt_i;
  logic [MANT_W-1:0] s_i;
  logic              is_exp_odd_i;
  logic              special_case_i;
  logic [RES_W-1:0]  res_o;
  logic              valid_o;
  logic              busy_o;

  modport master (
    output doSqrt_i, s_i, is_exp_odd_i, special_case_i,
    input  res_o, valid_o, busy_o
  );

  modport slave (
    input  doSqrt_i, s_i, is_exp_odd_i, special_case_i,
    output res_o, valid_o, busy_o
  );

endinterface

// File: rtl/lampfpu_sqrt_core.sv
// Iterative radix-2 restoring square root: one root bit per cycle, 1.15 result.
// Optional macro LAMP_SQRT_CORE_STICKY_EN ORs the inexact flag into the result LSB.
module lampfpu_sqrt_core #(
  parameter int MANT_W = 8,
  parameter int RES_W  = 2 * MANT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  lampfpu_sqrt_core_if.slave   sq,
  output logic [1:0]           o_dbg_state
);

  localparam int X_W   = 2 * RES_W;
  localparam int REM_W = RES_W + 2;
  localparam int CNT_W = $clog2(RES_W);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RES_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [X_W-1:0]     r_x;
  logic [REM_W-1:0]   r_rem;
  logic [RES_W-1:0]   r_root;
  logic [CNT_W-1:0]   r_cnt;
  logic [RES_W-1:0]   r_res;
  logic               r_valid;

  logic [X_W-1:0]     w_x_ext;
  logic [X_W-1:0]     w_x_load;
  logic [REM_W-1:0]   w_rem_shift;
  logic [REM_W-1:0]   w_trial;
  logic               w_ge;
  logic [REM_W-1:0]   w_rem_next;
  logic [RES_W-1:0]   w_root_next;
  logic [RES_W-1:0]   w_res_final;

  // Odd exponents double the radicand so the halved exponent stays integral.
  assign w_x_ext  = {{(X_W - MANT_W){1'b0}}, sq.s_i};
  assign w_x_load = sq.is_exp_odd_i ? (w_x_ext << (RES_W + MANT_W))
                                    : (w_x_ext << (RES_W + MANT_W - 1));

  assign w_rem_shift = (r_rem << 2) | {{RES_W{1'b0}}, r_x[X_W-1 -: 2]};
  assign w_trial     = {r_root, 2'b01};
  assign w_ge        = (w_rem_shift >= w_trial);
  assign w_rem_next  = w_ge ? (w_rem_shift - w_trial) : w_rem_shift;
  assign w_root_next = {r_root[RES_W-2:0], w_ge};

`ifdef LAMP_SQRT_CORE_STICKY_EN
  assign w_res_final = r_root | {{(RES_W - 1){1'b0}}, (r_rem != '0)};
`else
  assign w_res_final = r_root;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (sq.doSqrt_i) begin
          w_state_next = sq.special_case_i ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (r_cnt == '0) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x     <= '0;
      r_rem   <= '0;
      r_root  <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sq.doSqrt_i) begin
            r_root <= '0;
            r_rem  <= '0;
            if (!sq.special_case_i) begin
              r_x   <= w_x_load;
              r_cnt <= CNT_INIT;
            end
          end
        end
        ST_CALC: begin
          r_x    <= r_x << 2;
          r_rem  <= w_rem_next;
          r_root <= w_root_next;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          r_res   <= w_res_final;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sq.res_o    = r_res;
  assign sq.valid_o  = r_valid;
  assign sq.busy_o   = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lampfpu_sqrt_core.sv
// Directed bench for lampfpu_sqrt_core: scoreboard queue of expected roots and
// result cycles, popped by a monitor on every valid_o.
module tb_lampfpu_sqrt_core;

  localparam int MANT_W = 8;
  localparam int RES_W  = 16;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         cyc;
  int         total;
  int         bad;

  logic [RES_W-1:0] exp_q[$];
  int               cyc_q[$];

  lampfpu_sqrt_core_if #(.MANT_W(MANT_W), .RES_W(RES_W)) sq_if ();

  lampfpu_sqrt_core #(.MANT_W(MANT_W), .RES_W(RES_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .sq          (sq_if),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=hung required=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (sq_if.valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL stray_valid actual=res 0x%0h at cycle %0d required=no valid", sq_if.res_o, cyc);
      end else begin
        check("result", 32'(sq_if.res_o), 32'(exp_q.pop_front()));
        check("latency_cycle", 32'(cyc), 32'(cyc_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic start_op(input logic [7:0] s, input logic odd, input logic sp,
                          input logic [15:0] exp_res, input bit push);
    @(negedge clk);
    sq_if.doSqrt_i       = 1'b1;
    sq_if.s_i            = s;
    sq_if.is_exp_odd_i   = odd;
    sq_if.special_case_i = sp;
    if (push) begin
      exp_q.push_back(exp_res);
      cyc_q.push_back(cyc + 1 + (sp ? 1 : RES_W + 1));
    end
    @(negedge clk);
    sq_if.doSqrt_i       = 1'b0;
    sq_if.special_case_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n = n + 1;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    cyc_q.delete();
  endtask

  logic [15:0] exp_odd80;

  initial begin
    total = 0;
    bad   = 0;
`ifdef LAMP_SQRT_CORE_STICKY_EN
    exp_odd80 = 16'hB505;
`else
    exp_odd80 = 16'hB504;
`endif
    sq_if.doSqrt_i       = 1'b0;
    sq_if.s_i            = '0;
    sq_if.is_exp_odd_i   = 1'b0;
    sq_if.special_case_i = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_res", 32'(sq_if.res_o), 32'd0);
    check("rst_valid", 32'(sq_if.valid_o), 32'd0);
    check("rst_busy", 32'(sq_if.busy_o), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // exact roots, sqrt(0), special case
    start_op(8'h80, 1'b0, 1'b0, 16'h8000, 1'b1);
    check("busy_in_calc", 32'(sq_if.busy_o), 32'd1);
    drain(40);
    start_op(8'hC8, 1'b0, 1'b0, 16'hA000, 1'b1);
    drain(40);
    start_op(8'h00, 1'b0, 1'b0, 16'h0000, 1'b1);
    drain(40);
    check("busy_idle", 32'(sq_if.busy_o), 32'd0);

    start_op(8'h80, 1'b1, 1'b0, exp_odd80, 1'b1);
    drain(40);

    start_op(8'hFF, 1'b1, 1'b1, 16'h0000, 1'b1);
    check("special_busy_done", 32'(sq_if.busy_o), 32'd1);
    @(negedge clk);
    check("special_busy_after", 32'(sq_if.busy_o), 32'd0);
    drain(10);

    // starts while busy (CALC and DONE) must be dropped; inputs change mid-op
    start_op(8'hC0, 1'b1, 1'b0, 16'hDDB3, 1'b1);
    repeat (3) @(negedge clk);
    sq_if.doSqrt_i     = 1'b1;
    sq_if.s_i          = 8'hFF;
    sq_if.is_exp_odd_i = 1'b0;
    repeat (2) @(negedge clk);
    sq_if.doSqrt_i = 1'b0;
    begin
      int n;
      n = 0;
      while (dbg_state != 2'd2 && n < 40) begin
        @(negedge clk);
        n = n + 1;
      end
      check("reach_done", 32'(dbg_state), 32'd2);
    end
    sq_if.doSqrt_i = 1'b1;
    @(negedge clk);
    sq_if.doSqrt_i = 1'b0;
    drain(10);
    repeat (25) @(negedge clk);

    // reset in the middle of an iteration run
    start_op(8'h80, 1'b1, 1'b0, 16'h0000, 1'b0);
    repeat (7) @(negedge clk);
    check("pre_abort_state", 32'(dbg_state), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(sq_if.busy_o), 32'd0);
    check("abort_valid", 32'(sq_if.valid_o), 32'd0);
    check("abort_res", 32'(sq_if.res_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    start_op(8'h80, 1'b0, 1'b0, 16'h8000, 1'b1);
    drain(40);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
